mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and shared-memory signals around mem_port_arbiter.
// slave is the arbiter's view; master is the requesters plus memory model side.
interface mem_port_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ready;
    logic [DW-1:0] if_rdata;

    logic          d_re;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ready;
    logic [DW-1:0] d_rdata;

    logic          mem_re;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    logic          stall;
    logic          err;

    modport slave (
        input  if_req, if_addr, d_re, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        output if_ready, if_rdata, d_ready, d_rdata,
        output mem_re, mem_we, mem_addr, mem_wdata, stall, err
    );

    modport master (
        output if_req, if_addr, d_re, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        input  if_ready, if_rdata, d_ready, d_rdata,
        input  mem_re, mem_we, mem_addr, mem_wdata, stall, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data load/store onto one memory port, with a
// bounded data burst while fetch waits and a per-transaction ack timeout.
module mem_port_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int TIMEOUT    = 15,
    parameter int MAX_DBURST = 3
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    localparam int DCW = (MAX_DBURST < 1) ? 1 : $clog2(MAX_DBURST + 1);
    localparam logic [DCW-1:0] DC_MAX  = DCW'(MAX_DBURST);
    localparam logic [7:0]     TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_if_ready;
    logic            r_d_ready;
    logic            r_err;
    logic            r_mem_re;
    logic            r_mem_we;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_wdata;
    logic [DW-1:0]   r_if_rdata;
    logic [DW-1:0]   r_d_rdata;
    logic [DCW-1:0]  r_dcnt;
    logic [7:0]      r_wait;

    logic            w_d_req;
    logic            w_pulse;
    logic            w_grant_if;
    logic            w_grant_d;
    logic            w_done;
    logic            w_timeout;

    assign w_d_req = bus.d_re | bus.d_we;
    // A requester still sees its own request high during its ready cycle, so
    // no grant is made while a completion pulse is out.
    assign w_pulse = r_if_ready | r_d_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_if  = 1'b0;
        w_grant_d   = 1'b0;
        w_done      = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_pulse) begin
                    if (w_d_req && (!bus.if_req || (r_dcnt < DC_MAX))) begin
                        w_grant_d   = 1'b1;
                        w_state_nxt = BUSY_D;
                    end else if (bus.if_req) begin
                        w_grant_if  = 1'b1;
                        w_state_nxt = BUSY_IF;
                    end
                end
            end
            BUSY_IF, BUSY_D: begin
                // ack takes priority over a timeout landing on the same edge
                if (bus.mem_ack) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_wait == TO_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_ready  <= 1'b0;
            r_d_ready   <= 1'b0;
            r_err       <= 1'b0;
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_dcnt      <= '0;
            r_wait      <= '0;
        end else begin
            r_if_ready <= 1'b0;
            r_d_ready  <= 1'b0;
            r_err      <= 1'b0;
            if (w_grant_d) begin
                r_mem_addr  <= bus.d_addr;
                r_mem_wdata <= bus.d_wdata;
                r_mem_we    <= bus.d_we;
                r_mem_re    <= bus.d_re & ~bus.d_we;
                r_wait      <= '0;
                if (bus.if_req && (r_dcnt < DC_MAX)) begin
                    r_dcnt <= r_dcnt + 1'b1;
                end
            end else if (w_grant_if) begin
                r_mem_addr  <= bus.if_addr;
                r_mem_wdata <= '0;
                r_mem_we    <= 1'b0;
                r_mem_re    <= 1'b1;
                r_wait      <= '0;
                r_dcnt      <= '0;
            end else if (w_done || w_timeout) begin
                r_mem_re <= 1'b0;
                r_mem_we <= 1'b0;
                r_err    <= w_timeout;
                // a timed-out transaction returns zero data
                if (r_state == BUSY_IF) begin
                    r_if_ready <= 1'b1;
                    r_if_rdata <= w_done ? bus.mem_rdata : '0;
                end else begin
                    r_d_ready <= 1'b1;
                    r_d_rdata <= w_done ? bus.mem_rdata : '0;
                end
            end else if (r_state != IDLE) begin
                r_wait <= r_wait + 8'd1;
            end
        end
    end

    assign bus.if_ready  = r_if_ready;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.d_ready   = r_d_ready;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.mem_re    = r_mem_re;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.err       = r_err;
    assign bus.stall     = (bus.if_req & ~r_if_ready) | (w_d_req & ~r_d_ready);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of single transactions followed
// by hand sequences for arbitration order, starvation limit and reset abort.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(16), .DW(16)) bus ();

    mem_port_arbiter #(
        .AW(16), .DW(16), .TIMEOUT(15), .MAX_DBURST(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        if_req;
        logic        d_re;
        logic        d_we;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          ack_dly;
        logic [15:0] rdata;
        logic        exp_re;
        logic        exp_we;
        int          exp_lat;
        logic        exp_err;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];
    int   lat;
    bit   held;
    bit   isd;
    bit   kind;
    bit   quiet;
    bit   exp_kind[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called one step after the grant edge; returns cycles until the ready pulse.
    task automatic wait_ready(input bit want_d, input int ack_dly, input logic [15:0] rd,
                              output int lat_o, output bit held_o);
        logic [33:0] snap;
        snap   = {bus.mem_re, bus.mem_we, bus.mem_addr, bus.mem_wdata};
        lat_o  = -1;
        held_o = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (c == ack_dly) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = rd;
            end
            tick();
            bus.mem_ack = 1'b0;
            if (want_d ? bus.d_ready : bus.if_ready) begin
                lat_o = c + 1;
                break;
            end
            if ({bus.mem_re, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== snap || bus.stall !== 1'b1)
                held_o = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got still running, expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.if_req = 0; bus.if_addr = '0; bus.d_re = 0; bus.d_we = 0;
        bus.d_addr = '0; bus.d_wdata = '0; bus.mem_ack = 0; bus.mem_rdata = '0;
        rst = 1'b1;

        //            ifr d_re d_we addr      wdata     dly rdata     re  we  lat err exp_rdata
        vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 2,  16'hBEEF, 1'b1, 1'b0, 3,  1'b0, 16'hBEEF};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000, 0,  16'h5A5A, 1'b1, 1'b0, 1,  1'b0, 16'h5A5A};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 16'h0020, 16'h1234, 1,  16'h0F0F, 1'b0, 1'b1, 2,  1'b0, 16'h0F0F};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 16'h0030, 16'hCAFE, 0,  16'h1111, 1'b0, 1'b1, 1,  1'b0, 16'h1111};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 16'h0044, 16'h0000, 99, 16'hFFFF, 1'b1, 1'b0, 15, 1'b1, 16'h0000};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 16'h0048, 16'h0000, 14, 16'h7777, 1'b1, 1'b0, 15, 1'b0, 16'h7777};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 16'h0080, 16'h0000, 99, 16'hFFFF, 1'b1, 1'b0, 15, 1'b1, 16'h0000};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 5,  16'hA5A5, 1'b1, 1'b0, 6,  1'b0, 16'hA5A5};
        exp_kind = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

        tick();
        tick();
        check("reset_outputs",
              {bus.if_ready, bus.d_ready, bus.mem_re, bus.mem_we, bus.err, bus.stall,
               bus.mem_addr, bus.mem_wdata}, 32'h0);
        check("reset_rdata", {bus.if_rdata, bus.d_rdata}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            bus.if_req  = vecs[i].if_req;
            bus.if_addr = vecs[i].addr;
            bus.d_re    = vecs[i].d_re;
            bus.d_we    = vecs[i].d_we;
            bus.d_addr  = vecs[i].addr;
            bus.d_wdata = vecs[i].wdata;
            isd         = vecs[i].d_re | vecs[i].d_we;
            #1;
            check($sformatf("v%0d_stall_req", i), bus.stall, 1'b1);
            tick();
            check($sformatf("v%0d_grant_re", i), bus.mem_re, vecs[i].exp_re);
            check($sformatf("v%0d_grant_we", i), bus.mem_we, vecs[i].exp_we);
            check($sformatf("v%0d_grant_addr", i), bus.mem_addr, vecs[i].addr);
            if (vecs[i].d_we)
                check($sformatf("v%0d_grant_wdata", i), bus.mem_wdata, vecs[i].wdata);
            wait_ready(isd, vecs[i].ack_dly, vecs[i].rdata, lat, held);
            check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_held_stall", i), held, 1'b1);
            check($sformatf("v%0d_err", i), bus.err, vecs[i].exp_err);
            check($sformatf("v%0d_rdata", i), isd ? bus.d_rdata : bus.if_rdata, vecs[i].exp_rdata);
            check($sformatf("v%0d_other_ready", i), isd ? bus.if_ready : bus.d_ready, 1'b0);
            bus.if_req = 0; bus.d_re = 0; bus.d_we = 0;
            tick();
            check($sformatf("v%0d_after", i),
                  {bus.if_ready, bus.d_ready, bus.err, bus.mem_re, bus.mem_we, bus.stall}, 32'h0);
            check($sformatf("v%0d_rdata_hold", i), isd ? bus.d_rdata : bus.if_rdata, vecs[i].exp_rdata);
        end

        // ack while idle must not complete anything
        bus.mem_ack = 1'b1; bus.mem_rdata = 16'hDEAD;
        tick();
        bus.mem_ack = 1'b0;
        tick();
        check("idle_ack_ready", {bus.if_ready, bus.d_ready, bus.err, bus.mem_re}, 32'h0);
        check("idle_ack_rdata", {bus.if_rdata, bus.d_rdata}, {16'hA5A5, 16'h7777});

        // simultaneous fetch and store: store first, fetch after the idle gap
        bus.if_req = 1; bus.if_addr = 16'h0100;
        bus.d_we = 1; bus.d_addr = 16'h0020; bus.d_wdata = 16'h1234;
        tick();
        check("sim_store_grant", {bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata},
              {1'b1, 1'b0, 16'h0020, 16'h1234});
        wait_ready(1'b1, 1, 16'h0000, lat, held);
        check("sim_store_lat", lat, 2);
        check("sim_store_no_if_ready", bus.if_ready, 1'b0);
        bus.d_we = 0;
        tick();
        check("sim_idle_gap", {bus.mem_re, bus.mem_we, bus.stall}, 3'b001);
        tick();
        check("sim_fetch_grant", {bus.mem_re, bus.mem_we, bus.mem_addr}, {1'b1, 1'b0, 16'h0100});
        wait_ready(1'b0, 0, 16'h4321, lat, held);
        check("sim_fetch_lat", lat, 1);
        check("sim_fetch_rdata", bus.if_rdata, 16'h4321);
        bus.if_req = 0;
        tick();

        // data burst limit while fetch is pending
        bus.if_req = 1; bus.if_addr = 16'h0200;
        bus.d_re = 1; bus.d_addr = 16'h0300;
        for (int g = 0; g < 6; g++) begin
            if (g > 0) tick();
            tick();
            kind = (bus.mem_addr == 16'h0300);
            check($sformatf("starve_grant%0d", g), {bus.mem_re, kind}, {1'b1, exp_kind[g]});
            wait_ready(kind, 0, 16'h1000 + 16'(g), lat, held);
            check($sformatf("starve_lat%0d", g), lat, 1);
            if (!kind) bus.if_req = 0;
        end
        bus.d_re = 0; bus.if_req = 0;
        tick();

        // reset in the middle of a load abandons it silently
        bus.d_re = 1; bus.d_addr = 16'h0050;
        tick();
        check("rst_pre_grant", bus.mem_re, 1'b1);
        tick();
        rst = 1'b1;
        #1;
        check("rst_async_drop", {bus.mem_re, bus.mem_we}, 2'b00);
        quiet = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            if (bus.d_ready !== 1'b0 || bus.err !== 1'b0) quiet = 1'b0;
        end
        check("rst_no_pulse", quiet, 1'b1);
        check("rst_rdata_cleared", bus.d_rdata, 16'h0000);
        rst = 1'b0;
        #1;
        check("rst_no_early_grant", bus.mem_re, 1'b0);
        tick();
        check("rst_fresh_grant", {bus.mem_re, bus.mem_addr}, {1'b1, 16'h0050});
        wait_ready(1'b1, 1, 16'h9999, lat, held);
        check("rst_fresh_lat", lat, 2);
        check("rst_fresh_result", {bus.err, bus.d_rdata}, {1'b0, 16'h9999});
        bus.d_re = 0;
        tick();
        check("rst_fresh_after", {bus.d_ready, bus.mem_re}, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
